// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM initiator and its response FIFO.
package sp_ram_pkg;

    localparam int unsigned RAM_DATA_WIDTH = 64;
    localparam int unsigned RAM_BYTES      = RAM_DATA_WIDTH / 8;

    // Controller phase: zero-fill sweep, then normal request traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Small circular FIFO that holds read data until the requester accepts it.
module sp_ram_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic             Push_SI,
    input  logic [WIDTH-1:0] PushData_DI,
    input  logic             Pop_SI,
    output logic [WIDTH-1:0] PopData_DO,
    output logic             Full_SO,
    output logic             Empty_SO,
    output logic [CNT_W-1:0] Count_DO
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_c;
    logic             pop_c;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Only entries already stored can be popped, so a push is never visible in its own cycle.
    assign pop_c  = Pop_SI && (count_q != '0);
    assign push_c = Push_SI && (count_q != CNT_W'(DEPTH));

    // Storage, pointers and occupancy.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= PushData_DI;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign Empty_SO   = (count_q == '0);
    assign Full_SO    = (count_q == CNT_W'(DEPTH));
    assign Count_DO   = count_q;
    assign PopData_DO = Empty_SO ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sp_ram_initiator.sv
// Request/response front end for a single-port RAM: zero-fills after reset,
// then forwards requests and returns read data in order through a small FIFO.
module sp_ram_initiator
    import sp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned OUT_REGS   = 0,
    parameter int unsigned INIT_ZERO  = 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      ReqValid_SI,
    output logic                      ReqReady_SO,
    input  logic                      ReqWrite_SI,
    input  logic [RAM_BYTES-1:0]      ReqBEn_SI,
    input  logic [ADDR_WIDTH-1:0]     ReqAddr_DI,
    input  logic [RAM_DATA_WIDTH-1:0] ReqWData_DI,
    output logic                      RspValid_SO,
    input  logic                      RspReady_SI,
    output logic [RAM_DATA_WIDTH-1:0] RspRData_DO,
    output logic                      CSel_SO,
    output logic                      WrEn_SO,
    output logic [RAM_BYTES-1:0]      BEn_SO,
    output logic [ADDR_WIDTH-1:0]     Addr_DO,
    output logic [RAM_DATA_WIDTH-1:0] WrData_DO,
    input  logic [RAM_DATA_WIDTH-1:0] RdData_DI,
    output logic                      InitDone_SO
);

    localparam int unsigned RD_LAT = 1 + OUT_REGS;
    localparam int unsigned FDEPTH = RD_LAT + 1;
    localparam int unsigned CNT_W  = $clog2(FDEPTH + 1);

    ram_state_e         state_q;
    logic [31:0]        init_cnt_q;
    logic [RD_LAT-1:0]  inflight_q;
    logic [CNT_W-1:0]   inflight_cnt_c;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W:0]     occupancy_c;
    logic               fifo_empty;
    logic               fifo_full;
    logic               run_c;
    logic               sweep_c;
    logic               accept_c;
    logic               rd_accept_c;
    logic               push_c;
    logic               pop_c;

    // Phase control: sweep every word once, then serve traffic.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            if ((INIT_ZERO == 0) || (init_cnt_q == 32'(DATA_DEPTH - 1))) begin
                state_q    <= ST_RUN;
                init_cnt_q <= '0;
            end else begin
                init_cnt_q <= init_cnt_q + 32'd1;
            end
        end
    end

    assign run_c       = (state_q == ST_RUN);
    assign InitDone_SO = run_c;
    // The reset term keeps the RAM idle while reset is held.
    assign sweep_c     = (state_q == ST_INIT) && (INIT_ZERO != 0) && !Rst_RI;

    // Number of reads whose data is still on its way back from the RAM.
    always_comb begin
        inflight_cnt_c = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_cnt_c = inflight_cnt_c + CNT_W'(inflight_q[i]);
        end
    end

    // Credit check: every outstanding read owns a FIFO slot; a pop this cycle frees one.
    assign pop_c       = RspReady_SI && !fifo_empty;
    assign occupancy_c = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(inflight_cnt_c) - (CNT_W+1)'(pop_c);
    assign ReqReady_SO = run_c && (occupancy_c < (CNT_W+1)'(FDEPTH)) && !(fifo_full && !pop_c);
    assign accept_c    = ReqValid_SI && ReqReady_SO;
    assign rd_accept_c = accept_c && !ReqWrite_SI;
    assign push_c      = inflight_q[RD_LAT-1];

    // Tracks accepted reads until the RAM data for each is valid.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            inflight_q <= '0;
        end else begin
            inflight_q[0] <= rd_accept_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end
        end
    end

    // RAM drive: zero-fill sweep, pass-through of an accepted request, or idle.
    always_comb begin
        CSel_SO   = 1'b0;
        WrEn_SO   = 1'b0;
        BEn_SO    = '0;
        Addr_DO   = '0;
        WrData_DO = '0;
        if (sweep_c) begin
            CSel_SO = 1'b1;
            WrEn_SO = 1'b1;
            BEn_SO  = '1;
            Addr_DO = ADDR_WIDTH'(init_cnt_q);
        end else if (accept_c) begin
            CSel_SO   = 1'b1;
            WrEn_SO   = ReqWrite_SI;
            BEn_SO    = ReqBEn_SI;
            Addr_DO   = ReqAddr_DI;
            WrData_DO = ReqWData_DI;
        end
    end

    sp_ram_rsp_fifo #(
        .DEPTH (FDEPTH),
        .WIDTH (RAM_DATA_WIDTH)
    ) u_rsp_fifo (
        .Clk_CI      (Clk_CI),
        .Rst_RI      (Rst_RI),
        .Push_SI     (push_c),
        .PushData_DI (RdData_DI),
        .Pop_SI      (pop_c),
        .PopData_DO  (RspRData_DO),
        .Full_SO     (fifo_full),
        .Empty_SO    (fifo_empty),
        .Count_DO    (fifo_cnt)
    );

    assign RspValid_SO = !fifo_empty;

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Scoreboard bench for sp_ram_initiator driving a behavioural RAM with one output register.
module tb_sp_ram_initiator;

    localparam int unsigned AW     = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned OREGS  = 1;
    localparam int unsigned RD_LAT = 1 + OREGS;
    localparam int unsigned FDEPTH = RD_LAT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ReqValid = 1'b0;
    logic          ReqReady;
    logic          ReqWrite = 1'b0;
    logic [7:0]    ReqBEn = '0;
    logic [AW-1:0] ReqAddr = '0;
    logic [63:0]   ReqWData = '0;
    logic          RspValid;
    logic          RspReady = 1'b1;
    logic [63:0]   RspRData;
    logic          CSel;
    logic          WrEn;
    logic [7:0]    BEn;
    logic [AW-1:0] Addr;
    logic [63:0]   WrData;
    logic [63:0]   RdData;
    logic          InitDone;

    always #5 clk = ~clk;

    sp_ram_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_DEPTH (DEPTH),
        .OUT_REGS   (OREGS),
        .INIT_ZERO  (1)
    ) dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .ReqValid_SI (ReqValid),
        .ReqReady_SO (ReqReady),
        .ReqWrite_SI (ReqWrite),
        .ReqBEn_SI   (ReqBEn),
        .ReqAddr_DI  (ReqAddr),
        .ReqWData_DI (ReqWData),
        .RspValid_SO (RspValid),
        .RspReady_SI (RspReady),
        .RspRData_DO (RspRData),
        .CSel_SO     (CSel),
        .WrEn_SO     (WrEn),
        .BEn_SO      (BEn),
        .Addr_DO     (Addr),
        .WrData_DO   (WrData),
        .RdData_DI   (RdData),
        .InitDone_SO (InitDone)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] ben);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (ben[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural RAM: synchronous read plus one output register.
    logic [63:0] ram [DEPTH];
    logic [63:0] q1 = '0;
    logic [63:0] q2 = '0;
    always @(posedge clk) begin
        if (CSel) begin
            if (WrEn) ram[Addr] <= merge(ram[Addr], WrData, BEn);
            else      q1 <= ram[Addr];
        end
        q2 <= q1;
    end
    assign RdData = q2;

    // Reference contents as seen by the requester, and expected responses.
    logic [63:0]  ref_mem [DEPTH];
    logic [63:0]  exp_q[$];
    int           acc_edges[$];
    int           rsp_edges[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           log_timing = 1'b0;
    int           rsp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Response-ready driver: 0 = always ready, 1 = never ready, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            RspReady = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every delivered response and checks hold behaviour.
    logic        prev_valid = 1'b0;
    logic        prev_pop   = 1'b0;
    logic [63:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_pop   = 1'b0;
        end else begin
            if (prev_valid && !prev_pop) begin
                chk("rsp_hold_valid", 64'(RspValid), 64'd1);
                chk("rsp_hold_data", RspRData, prev_data);
            end
            if (RspValid && RspReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h expected no response", RspRData);
                end else begin
                    chk("rsp_data", RspRData, exp_q.pop_front());
                end
                if (log_timing) rsp_edges.push_back(cyc);
            end
            prev_valid = RspValid;
            prev_pop   = RspValid && RspReady;
            prev_data  = RspRData;
        end
    end

    // Issue one request and hold it until accepted; called at posedge+1.
    task automatic issue(input logic wr, input logic [7:0] ben, input logic [AW-1:0] addr,
                         input logic [63:0] data);
        int budget;
        bit done;
        budget   = 200;
        done     = 1'b0;
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqBEn   = ben;
        ReqAddr  = addr;
        ReqWData = data;
        while (!done) begin
            @(negedge clk);
            if (ReqReady) begin
                done = 1'b1;
                if (wr) begin
                    ref_mem[addr] = merge(ref_mem[addr], data, ben);
                end else begin
                    exp_q.push_back(ref_mem[addr]);
                    if (log_timing) acc_edges.push_back(cyc + 1);
                end
            end else begin
                budget--;
                if (budget == 0) begin
                    fail_now("req_accept_timeout");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        ReqValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget   = 200;
        ReqValid = 1'b0;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        idle(2);
    endtask

    // Zero-fill sweep after reset release; starts just after rst falls at posedge+1.
    task automatic check_init();
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            chk("init_addr", 64'(Addr), 64'(i));
            chk("init_ctl", 64'({CSel, WrEn, BEn, InitDone, ReqReady}), 64'({1'b1, 1'b1, 8'hFF, 1'b0, 1'b0}));
            chk("init_wdata", WrData, 64'd0);
        end
        @(negedge clk);
        chk("init_done", 64'({InitDone, CSel}), 64'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ReqValid = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_req_ready", 64'(ReqReady), 64'd0);
        chk("rst_rsp_valid", 64'(RspValid), 64'd0);
        chk("rst_rsp_data", RspRData, 64'd0);
        chk("rst_init_done", 64'(InitDone), 64'd0);
        chk("rst_csel", 64'(CSel), 64'd0);
        chk("rst_wren", 64'(WrEn), 64'd0);
        chk("rst_ben", 64'(BEn), 64'd0);
        chk("rst_addr", 64'(Addr), 64'd0);
        chk("rst_wdata", WrData, 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_init();
    endtask

    initial begin
        int acc;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = {$urandom, $urandom};
        @(posedge clk);
        #1;
        do_reset();

        // Zero-filled word reads back as zero.
        issue(1'b0, 8'h00, 4'd5, 64'd0);
        drain();

        // Partial-byte write merges with existing bytes.
        issue(1'b1, 8'hFF, 4'd3, 64'h1122334455667788);
        issue(1'b1, 8'h0F, 4'd3, 64'hAAAAAAAAAAAAAAAA);
        issue(1'b0, 8'h00, 4'd3, 64'd0);
        drain();

        // Back-to-back reads: latency and one-per-cycle throughput.
        for (int i = 0; i < 8; i++) issue(1'b1, 8'hFF, AW'(i), {$urandom, $urandom});
        idle(1);
        log_timing = 1'b1;
        for (int i = 0; i < 8; i++) issue(1'b0, 8'h00, AW'(i), 64'd0);
        drain();
        log_timing = 1'b0;
        chk("b2b_rsp_count", 64'(rsp_edges.size()), 64'd8);
        chk("b2b_acc_count", 64'(acc_edges.size()), 64'd8);
        if (rsp_edges.size() == 8 && acc_edges.size() == 8) begin
            chk("b2b_first_latency", 64'(rsp_edges[0] - acc_edges[0]), 64'(RD_LAT));
            for (int k = 1; k < 8; k++) begin
                chk("b2b_acc_spacing", 64'(acc_edges[k] - acc_edges[k-1]), 64'd1);
                chk("b2b_rsp_spacing", 64'(rsp_edges[k] - rsp_edges[k-1]), 64'd1);
            end
        end

        // Back-pressure: exactly FDEPTH reads fit while responses are stalled.
        rsp_mode = 1;
        RspReady = 1'b0;
        idle(1);
        acc      = 0;
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ReqAddr = AW'(k);
            @(negedge clk);
            if (ReqReady) begin
                acc++;
                exp_q.push_back(ref_mem[AW'(k)]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_accepts", 64'(acc), 64'(FDEPTH));
        chk("bp_ready_low", 64'(ReqReady), 64'd0);
        @(posedge clk);
        #1;
        rsp_mode = 0;
        drain();

        // Reset with two reads in flight and one response queued.
        rsp_mode = 1;
        RspReady = 1'b0;
        idle(1);
        issue(1'b0, 8'h00, 4'd1, 64'd0);
        issue(1'b0, 8'h00, 4'd2, 64'd0);
        issue(1'b0, 8'h00, 4'd3, 64'd0);
        ReqValid = 1'b0;
        chk("pre_rst_rsp_valid", 64'(RspValid), 64'd1);
        do_reset();
        rsp_mode = 0;
        idle(6);
        issue(1'b0, 8'h00, 4'd3, 64'd0);
        drain();

        // Randomised mixed traffic with random response back-pressure.
        rsp_mode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(1'($urandom_range(0, 1)), 8'($urandom), AW'($urandom_range(0, DEPTH - 1)),
                  {$urandom, $urandom});
        end
        rsp_mode = 0;
        drain();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
